// File: rtl/secp256k1_mult_arb_pkg.sv
// Shared widths and helpers for the secp256k1 multiplier arbiter.
package secp256k1_mult_arb_pkg;

    // Field-element width and default ctl width used by the point engines.
    localparam int unsigned FE_BITS      = 256;
    localparam int unsigned CTL_BITS_DEF = 16;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/secp256k1_mult_arb_rr_arb.sv
// Combinational round-robin arbiter: search starts at ptr and wraps around.
module secp256k1_mult_arb_rr_arb #(
    parameter int unsigned NUM_IN  = 2,
    parameter int unsigned ID_BITS = 1
) (
    input  logic [NUM_IN-1:0]  req,
    input  logic [ID_BITS-1:0] ptr,
    output logic [NUM_IN-1:0]  gnt,
    output logic [ID_BITS-1:0] gnt_idx,
    output logic               gnt_any
);

    // Two passes: ptr..NUM_IN-1 first, then 0..ptr-1 for the wrap-around.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (!gnt_any && i >= int'(ptr) && req[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = ID_BITS'(i);
                gnt_any = 1'b1;
            end
        end
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (!gnt_any && i < int'(ptr) && req[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = ID_BITS'(i);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/secp256k1_mult_arb.sv
// Shares one multiplier between NUM_IN requesters: tags requests with the
// requester index on the way in and routes results back by that tag.
module secp256k1_mult_arb
    import secp256k1_mult_arb_pkg::*;
#(
    parameter int unsigned NUM_IN   = 2,
    parameter int unsigned DAT_BITS = 2 * FE_BITS,
    parameter int unsigned RES_BITS = FE_BITS,
    parameter int unsigned CTL_BITS = CTL_BITS_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_IN-1:0]            i_val,
    input  logic [NUM_IN*DAT_BITS-1:0]   i_dat,
    input  logic [NUM_IN*CTL_BITS-1:0]   i_ctl,
    output logic [NUM_IN-1:0]            o_rdy,
    output logic                         o_mul_val,
    output logic [DAT_BITS-1:0]          o_mul_dat,
    output logic [CTL_BITS-1:0]          o_mul_ctl,
    input  logic                         i_mul_rdy,
    input  logic                         i_mul_val,
    input  logic [RES_BITS-1:0]          i_mul_dat,
    input  logic [CTL_BITS-1:0]          i_mul_ctl,
    output logic                         o_mul_rdy,
    output logic [NUM_IN-1:0]            o_val,
    output logic [RES_BITS-1:0]          o_dat,
    output logic [CTL_BITS-1:0]          o_ctl,
    input  logic [NUM_IN-1:0]            i_rdy,
    output logic                         o_err
);

    localparam int unsigned ID_BITS  = clog2_min1(NUM_IN);
    localparam int unsigned OWN_BITS = CTL_BITS - ID_BITS;

    logic [NUM_IN-1:0]   gnt;
    logic [ID_BITS-1:0]  gnt_idx;
    logic                gnt_any;
    logic [ID_BITS-1:0]  ptr_q;
    logic                load;
    logic [DAT_BITS-1:0] sel_dat;
    logic [CTL_BITS-1:0] sel_ctl;
    logic                unused_sel_tag;

    logic [ID_BITS-1:0]  tag_q;
    logic [ID_BITS-1:0]  tag_in;
    logic                tag_ok;
    logic                res_acc;

    secp256k1_mult_arb_rr_arb #(
        .NUM_IN  (NUM_IN),
        .ID_BITS (ID_BITS)
    ) u_rr_arb (
        .req     (i_val),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Request register can take a new beat when empty or draining this cycle.
    assign load  = ~o_mul_val | i_mul_rdy;
    assign o_rdy = load ? gnt : '0;

    // Select the granted requester's operands and ctl.
    always_comb begin
        sel_dat = '0;
        sel_ctl = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (gnt[i]) begin
                sel_dat = i_dat[i*DAT_BITS +: DAT_BITS];
                sel_ctl = i_ctl[i*CTL_BITS +: CTL_BITS];
            end
        end
    end

    // Requester-supplied tag bits are overwritten by the grant index.
    assign unused_sel_tag = ^sel_ctl[CTL_BITS-1 -: ID_BITS];

    // Request output register and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mul_val <= 1'b0;
            ptr_q     <= '0;
        end else if (load) begin
            o_mul_val <= gnt_any;
            if (gnt_any) begin
                o_mul_dat <= sel_dat;
                o_mul_ctl <= {gnt_idx, sel_ctl[OWN_BITS-1:0]};
                ptr_q     <= (gnt_idx == ID_BITS'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    assign tag_in    = i_mul_ctl[CTL_BITS-1 -: ID_BITS];
    assign tag_ok    = 32'(tag_in) < NUM_IN;
    // tag_q names the owner of the held result, so only its i_rdy matters.
    assign o_mul_rdy = ~(|o_val) | i_rdy[tag_q];
    assign res_acc   = i_mul_val & o_mul_rdy;

    // Response output register; out-of-range tags are dropped and flagged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_val <= '0;
            o_err <= 1'b0;
            tag_q <= '0;
        end else if (res_acc) begin
            if (tag_ok) begin
                o_val <= NUM_IN'(1) << tag_in;
                o_dat <= i_mul_dat;
                o_ctl <= {{ID_BITS{1'b0}}, i_mul_ctl[OWN_BITS-1:0]};
                tag_q <= tag_in;
            end else begin
                o_val <= '0;
                o_err <= 1'b1;
            end
        end else if (i_rdy[tag_q]) begin
            o_val <= '0;
        end
    end

endmodule

// File: tb/tb_secp256k1_mult_arb.sv
// Scoreboard bench for secp256k1_mult_arb with an in-bench multiplier model.
module tb_secp256k1_mult_arb;

    localparam int N  = 2;
    localparam int DB = 512;
    localparam int RB = 256;
    localparam int CB = 16;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [14:0] own;
        logic        tagbit;
    } req_t;

    typedef struct {
        logic [RB-1:0] res;
        logic [CB-1:0] ctl;
    } mres_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    i_val, o_rdy, o_val, i_rdy;
    logic [N*DB-1:0] i_dat;
    logic [N*CB-1:0] i_ctl;
    logic            o_mul_val, i_mul_rdy, i_mul_val, o_mul_rdy, o_err;
    logic [DB-1:0]   o_mul_dat;
    logic [CB-1:0]   o_mul_ctl, i_mul_ctl, o_ctl;
    logic [RB-1:0]   i_mul_dat, o_dat;

    logic [2:0]      i_val3, o_rdy3, o_val3, i_rdy3;
    logic [3*DB-1:0] i_dat3;
    logic [3*CB-1:0] i_ctl3;
    logic            o_mul_val3, i_mul_rdy3, i_mul_val3, o_mul_rdy3, o_err3;
    logic [DB-1:0]   o_mul_dat3;
    logic [CB-1:0]   o_mul_ctl3, i_mul_ctl3, o_ctl3;
    logic [RB-1:0]   i_mul_dat3, o_dat3;

    secp256k1_mult_arb #(.NUM_IN(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_val(i_val), .i_dat(i_dat), .i_ctl(i_ctl), .o_rdy(o_rdy),
        .o_mul_val(o_mul_val), .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl),
        .i_mul_rdy(i_mul_rdy), .i_mul_val(i_mul_val), .i_mul_dat(i_mul_dat),
        .i_mul_ctl(i_mul_ctl), .o_mul_rdy(o_mul_rdy), .o_val(o_val), .o_dat(o_dat),
        .o_ctl(o_ctl), .i_rdy(i_rdy), .o_err(o_err)
    );

    secp256k1_mult_arb #(.NUM_IN(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_val(i_val3), .i_dat(i_dat3), .i_ctl(i_ctl3),
        .o_rdy(o_rdy3), .o_mul_val(o_mul_val3), .o_mul_dat(o_mul_dat3),
        .o_mul_ctl(o_mul_ctl3), .i_mul_rdy(i_mul_rdy3), .i_mul_val(i_mul_val3),
        .i_mul_dat(i_mul_dat3), .i_mul_ctl(i_mul_ctl3), .o_mul_rdy(o_mul_rdy3),
        .o_val(o_val3), .o_dat(o_dat3), .o_ctl(o_ctl3), .i_rdy(i_rdy3), .o_err(o_err3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    req_t  req_q    [N][$];
    req_t  exp_req  [N][$];
    req_t  exp_resp [N][$];
    mres_t mul_q    [$];
    int    grant_log[$];
    bit    raised   [N];
    int    waiting  [N];
    bit    mul_out_v;
    int    val_prob, mul_rdy_prob, resp_prob, out_rdy_prob;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DB-1:0] mk_dat(input req_t r);
        logic [DB-1:0] d;
        d = '0;
        d[31:0]    = r.a;
        d[256+:32] = r.b;
        return d;
    endfunction

    function automatic req_t mk_req(input logic [31:0] a, input logic [31:0] b,
                                    input logic [14:0] own);
        req_t r;
        r.a = a; r.b = b; r.own = own; r.tagbit = 1'b0;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.a = $urandom; r.b = $urandom; r.own = 15'($urandom); r.tagbit = 1'($urandom);
        return r;
    endfunction

    // Capture handshakes just before the edge, then advance to edge + 1.
    task automatic tick();
        req_t r;
        logic [RB-1:0] p;
        @(negedge clk);
        if (!rst) begin
            for (int n = 0; n < N; n++) begin
                if (i_val[n] && o_rdy[n] && req_q[n].size() > 0) begin
                    r = req_q[n].pop_front();
                    exp_req[n].push_back(r);
                    exp_resp[n].push_back(r);
                    raised[n] = 1'b0;
                    grant_log.push_back(n);
                    check("fair_wait", waiting[n] <= N - 1, 1);
                    waiting[n] = 0;
                    for (int m = 0; m < N; m++) if (m != n && i_val[m]) waiting[m]++;
                end
            end
            if (o_mul_val && i_mul_rdy) begin
                p = o_mul_dat[255:0] * o_mul_dat[511:256];
                mul_q.push_back('{res: p, ctl: o_mul_ctl});
            end
            if (i_mul_val && o_mul_rdy && mul_q.size() > 0) begin
                void'(mul_q.pop_front());
                mul_out_v = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int n = 0; n < N; n++) begin
            if (!raised[n] && req_q[n].size() > 0 && $urandom_range(99) < val_prob)
                raised[n] = 1'b1;
            i_val[n] = raised[n];
            if (raised[n]) begin
                i_dat[n*DB +: DB] = mk_dat(req_q[n][0]);
                i_ctl[n*CB +: CB] = {req_q[n][0].tagbit, req_q[n][0].own};
            end
        end
        i_mul_rdy = $urandom_range(99) < mul_rdy_prob;
        if (!mul_out_v && mul_q.size() > 0 && $urandom_range(99) < resp_prob) mul_out_v = 1'b1;
        i_mul_val = mul_out_v;
        if (mul_out_v) begin
            i_mul_dat = mul_q[0].res;
            i_mul_ctl = mul_q[0].ctl;
        end
        for (int n = 0; n < N; n++) i_rdy[n] = $urandom_range(99) < out_rdy_prob;
    endtask

    task automatic step();
        tick();
        drive();
    endtask

    task automatic set_probs(input int v, input int mr, input int rp, input int orr);
        val_prob = v; mul_rdy_prob = mr; resp_prob = rp; out_rdy_prob = orr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int n = 0; n < N; n++) begin
            req_q[n].delete(); exp_req[n].delete(); exp_resp[n].delete();
            raised[n] = 1'b0; waiting[n] = 0;
        end
        mul_q.delete();
        grant_log.delete();
        mul_out_v = 1'b0;
        i_val = '0; i_mul_val = 1'b0; i_mul_rdy = 1'b1; i_rdy = '1;
        tick();
        rst = 1'b0;
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = !o_mul_val && o_val == '0 && mul_q.size() == 0 && !mul_out_v;
        for (int n = 0; n < N; n++)
            if (req_q[n].size() || exp_req[n].size() || exp_resp[n].size()) idle = 0;
        return idle;
    endfunction

    task automatic drain();
        bit done;
        set_probs(100, 100, 100, 100);
        done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (all_idle()) done = 1;
            else step();
        end
        check("drain_done", done, 1);
    endtask

    // Monitor: scoreboard pops and stability of held outputs.
    bit            prev_rst = 1'b1;
    bit            hold_mul, hold_out;
    logic [DB-1:0] hm_dat;
    logic [CB-1:0] hm_ctl, ho_ctl;
    logic [N-1:0]  ho_val;
    logic [RB-1:0] ho_dat;

    always @(negedge clk) begin
        req_t r;
        int t;
        logic [63:0] pr;
        if (!rst && !prev_rst) begin
            if (hold_mul) begin
                check("mul_hold_val", o_mul_val, 1);
                check("mul_hold_dat", o_mul_dat, hm_dat);
                check("mul_hold_ctl", o_mul_ctl, hm_ctl);
            end
            if (hold_out) begin
                check("out_hold_val", o_val, ho_val);
                check("out_hold_dat", o_dat, ho_dat);
                check("out_hold_ctl", o_ctl, ho_ctl);
            end
        end
        if (!rst) begin
            if (o_mul_val && i_mul_rdy) begin
                t = int'(o_mul_ctl[CB-1]);
                if (exp_req[t].size() == 0) check("req_unexpected", o_mul_ctl, 'x);
                else begin
                    r = exp_req[t].pop_front();
                    check("req_dat", o_mul_dat, mk_dat(r));
                    check("req_ctl", o_mul_ctl[14:0], r.own);
                end
            end
            check("oval_onehot", $countones(o_val) <= 1, 1);
            for (int n = 0; n < N; n++) begin
                if (o_val[n] && i_rdy[n]) begin
                    if (exp_resp[n].size() == 0) check("resp_unexpected", o_val, 0);
                    else begin
                        r  = exp_resp[n].pop_front();
                        pr = 64'(r.a) * 64'(r.b);
                        check("resp_dat", o_dat, pr);
                        check("resp_ctl", o_ctl, {1'b0, r.own});
                    end
                end
            end
        end
        prev_rst = rst;
        hold_mul = o_mul_val && !i_mul_rdy;
        hm_dat   = o_mul_dat;
        hm_ctl   = o_mul_ctl;
        hold_out = |(o_val & ~i_rdy);
        ho_val   = o_val;
        ho_dat   = o_dat;
        ho_ctl   = o_ctl;
    end

    initial begin
        logic [CB-1:0] saved_ctl;
        bit found;
        i_dat = '0; i_ctl = '0; i_mul_dat = '0; i_mul_ctl = '0;
        i_val3 = '0; i_dat3 = '0; i_ctl3 = '0; i_mul_rdy3 = 1'b1; i_mul_val3 = 1'b0;
        i_mul_dat3 = '0; i_mul_ctl3 = '0; i_rdy3 = '1;
        set_probs(100, 100, 100, 100);
        do_reset();
        check("rst_mul_val", o_mul_val, 0);
        check("rst_val", o_val, 0);
        check("rst_err", o_err, 0);

        // Single request from requester 0: 3 * 5 with ctl 0x0012.
        req_q[0].push_back(mk_req(3, 5, 15'h0012));
        drive(); tick();
        check("t1_mul_val", o_mul_val, 1);
        check("t1_mul_ctl", o_mul_ctl, 16'h0012);
        check("t1_mul_dat", o_mul_dat, mk_dat(mk_req(3, 5, 0)));
        drive(); tick();
        check("t1_mul_idle", o_mul_val, 0);
        drive(); tick();
        check("t1_val", o_val, 2'b01);
        check("t1_dat", o_dat, 15);
        check("t1_ctl", o_ctl, 16'h0012);
        drive(); tick();
        check("t1_val_clr", o_val, 0);
        drain();

        // Both requesters continuously valid: strict alternation from 0.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req_q[0].push_back(rand_req());
            req_q[1].push_back(rand_req());
        end
        drive();
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t2_mul_val", o_mul_val, 1);
            check("t2_tag", o_mul_ctl[15], k % 2);
            drive();
        end
        check("t2_grants", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) check("t2_order", grant_log[k], k % 2);
        drain();

        // Multiplier stall with a held request from requester 1.
        grant_log.delete();
        set_probs(100, 0, 100, 100);
        req_q[1].push_back(rand_req());
        drive(); tick();
        check("t3_load", o_mul_val, 1);
        saved_ctl = o_mul_ctl;
        check("t3_tag", saved_ctl[15], 1);
        req_q[0].push_back(rand_req());
        req_q[1].push_back(rand_req());
        drive();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_hold_val", o_mul_val, 1);
            check("t3_hold_ctl", o_mul_ctl, saved_ctl);
            check("t3_rdy_low", o_rdy, 0);
            drive();
        end
        mul_rdy_prob = 100;
        drive(); tick();
        check("t3_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) check("t3_next", grant_log[1], 0);
        check("t3_next_tag", o_mul_ctl[15], 0);
        drive();
        drain();

        // Response backpressure on requester 1.
        set_probs(100, 100, 100, 0);
        req_q[1].push_back(mk_req(7, 9, 15'h0034));
        drive(); tick();
        req_q[0].push_back(mk_req(2, 4, 15'h0001));
        drive();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (o_val != 0) found = 1;
            drive();
        end
        check("t4_arrive", found, 1);
        check("t4_val", o_val, 2'b10);
        check("t4_ctl", o_ctl, 16'h0034);
        check("t4_dat", o_dat, 63);
        for (int k = 0; k < 3; k++) begin
            drive(); tick();
            check("t4_hold_val", o_val, 2'b10);
            check("t4_hold_ctl", o_ctl, 16'h0034);
            check("t4_mul_rdy", o_mul_rdy, 0);
        end
        out_rdy_prob = 100;
        drive(); #1;
        check("t4_release_rdy", o_mul_rdy, 1);
        tick();
        check("t4_next_val", o_val, 2'b01);
        check("t4_next_dat", o_dat, 8);
        drive();
        drain();

        // Three-requester instance: tag 3 is invalid and sets a sticky error.
        i_mul_val3 = 1'b1; i_mul_ctl3 = 16'hC0AB; i_mul_dat3 = 7;
        #1;
        check("t5_rdy", o_mul_rdy3, 1);
        tick();
        check("t5_no_val", o_val3, 0);
        check("t5_err", o_err3, 1);
        i_mul_ctl3 = 16'h80CD; i_mul_dat3 = 9;
        tick();
        check("t5_val2", o_val3, 3'b100);
        check("t5_dat2", o_dat3, 9);
        check("t5_ctl2", o_ctl3, 16'h00CD);
        i_mul_val3 = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("t5_err_sticky", o_err3, 1);
        do_reset();
        check("t5_err_clr", o_err3, 0);

        // Reset with both stages full.
        set_probs(100, 100, 100, 0);
        req_q[0].push_back(rand_req());
        drive();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (o_val != 0) found = 1;
            drive();
        end
        mul_rdy_prob = 0;
        req_q[1].push_back(rand_req());
        drive(); tick(); tick();
        check("t6_full", {o_mul_val, |o_val}, 2'b11);
        do_reset();
        check("t6_mul_val", o_mul_val, 0);
        check("t6_val", o_val, 0);
        check("t6_err", o_err, 0);
        set_probs(100, 100, 100, 100);
        req_q[1].push_back(rand_req());
        req_q[0].push_back(rand_req());
        drive(); tick();
        check("t6_first_tag", o_mul_ctl[15], 0);
        if (grant_log.size() > 0) check("t6_first_grant", grant_log[0], 0);
        else check("t6_first_grant", grant_log.size(), 1);
        drive();
        drain();

        // Randomized traffic with random backpressure on every interface.
        set_probs(70, 60, 60, 60);
        for (int k = 0; k < 800; k++) begin
            for (int n = 0; n < N; n++) if (req_q[n].size() < 3) req_q[n].push_back(rand_req());
            step();
        end
        drain();
        check("end_err", o_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/secp256k1_mult_arb.md
Name: secp256k1_mult_arb

Overview:
- Shares one secp256k1_mult_mod instance between NUM_IN requesters, e.g. ec_point_add and ec_point_dbl engines.
- Request path: round-robin arbitration of single-beat operand requests; requester index tagged into the top ctl bits.
- Response path: decodes the tag on the way back, routes the result to the owning requester and restores its ctl bits.
- Sits between the point engines' mul interfaces and the shared multiplier.

Parameters:
- NUM_IN, 2, number of requesters (2..8).
- DAT_BITS, 512, request data width (two 256-bit operands, a at [0+:256], b at [256+:256]).
- RES_BITS, 256, result width.
- CTL_BITS, 16, ctl width on every interface.
- ID_BITS, $clog2(NUM_IN) (min 1), tag width; occupies ctl[CTL_BITS-1 -: ID_BITS].

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_val  in  NUM_IN  per-requester request valid
- i_dat  in  NUM_IN*DAT_BITS  request operands, requester n at [n*DAT_BITS +: DAT_BITS]
- i_ctl  in  NUM_IN*CTL_BITS  request ctl; requester-owned bits are the low CTL_BITS-ID_BITS
- o_rdy  out  NUM_IN  per-requester request accept
- o_mul_val / o_mul_dat / o_mul_ctl  out  1 / DAT_BITS / CTL_BITS  to shared multiplier
- i_mul_rdy  in  1  multiplier accepts
- i_mul_val / i_mul_dat / i_mul_ctl  in  1 / RES_BITS / CTL_BITS  multiplier result
- o_mul_rdy  out  1  arbiter accepts result
- o_val  out  NUM_IN  per-requester result valid (at most one bit set)
- o_dat  out  RES_BITS  result, shared by all requesters
- o_ctl  out  CTL_BITS  result ctl with tag bits cleared to 0
- i_rdy  in  NUM_IN  per-requester result accept
- o_err  out  1  sticky: response arrived with tag >= NUM_IN

Behaviour:
- Reset: o_mul_val=0, o_val=0, o_err=0, RR pointer=0. Data/ctl registers are don't-care. Anything held is dropped. The shared multiplier shares i_rst, so in-flight results are also discarded.
- Handshake: a transfer occurs when val&rdy are high on a rising edge. Held outputs stay stable while val=1 and rdy=0.
- Request stage (1 output register):
  - Stage can load when o_mul_val==0 or i_mul_rdy==1.
  - Winner = first requester with i_val set, searching from ptr upward with wrap (ptr, ptr+1, …, NUM_IN-1, 0, …).
  - o_rdy[winner] = load condition. All other o_rdy bits are 0. o_rdy must not depend on i_val of the same requester beyond arbitration.
  - On load: o_mul_dat = winner's dat; o_mul_ctl = winner ctl with top ID_BITS replaced by winner index; o_mul_val=1; ptr <= winner+1 (wrap to 0).
  - With no requests, ptr holds. If the stage drains with no new winner, o_mul_val goes to 0.
  - Latency i_val→o_mul_val: 1 cycle. Back-to-back throughput: 1 per cycle.
- Response stage (1 output register):
  - tag = held o_ctl source tag.
  - o_mul_rdy = ~(|o_val) | i_rdy[tag] (held).
  - On accept:
    - valid tag: o_val[tag_in]=1, o_dat = i_mul_dat, o_ctl = i_mul_ctl with tag bits zeroed.
    - tag_in >= NUM_IN (possible only for non-power-of-2 NUM_IN): result dropped, o_err <= 1, o_val=0.
  - Latency: 1 cycle. Full throughput when the destination keeps i_rdy=1.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_IN-1 and no requester waits more than NUM_IN-1 grants.
- Simultaneous load and drain in the same cycle is legal on both stages; no bubble.
- Requests and responses are independent: the arbiter does not limit outstanding count or reorder (the multiplier is in-order).

Decomposition:
- common_pkg: clog2-with-min-1 helper for ID_BITS.
- secp256k1_pkg: default widths (256-bit fe_t, 16-bit ctl) only.
- One natural sub-module, rr_arb (NUM_IN requests, ptr, one-hot grant, combinational). It is reusable for future add/sub sharing.

Test Plan:
- Single requester 0, a=3, b=5, ctl=0x0012: o_mul_ctl=0x0012 one cycle later. Result 15 returns to o_val[0] with o_ctl=0x0012.
- Both requesters valid for 6 cycles, i_mul_rdy=1: grant order 0,1,0,1,0,1, and o_mul_ctl[15] alternates 0,1,0,1,0,1.
- i_mul_rdy=0 for 5 cycles while requester 1 is valid: o_mul_val/dat/ctl stay stable and o_rdy=0 throughout. First cycle after rdy returns: transfer, then requester 0 is granted next.
- Response with ctl=0x8034, i_rdy[1]=0 for 3 cycles: o_val=0b10 held with o_ctl=0x0034, o_mul_rdy=0. Release: accepted, and the next result is taken the same cycle.
- NUM_IN=3, response ctl top bits=3: o_mul_rdy=1, no o_val bit set, o_err=1 and stays 1 until i_rst.
- Assert i_rst while both stages are full: next cycle o_mul_val=0, o_val=0, o_err=0, and the first post-reset grant goes to requester 0.
